// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - elastic pipeline-stage register with flush; optional skid entry via PIPE_STAGE_BUF_SKID_EN
module pipe_stage_buf #(
  parameter int unsigned       DATA_W = 259,
  parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  // Occupancy state: EMPTY = nothing held, ONE = main entry valid, TWO = main and skid valid
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_v;
  logic              s_v;
  logic              in_fire;
  logic              out_fire;

  assign m_v = (state_q != ST_EMPTY);

`ifdef PIPE_STAGE_BUF_SKID_EN
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              in_ready_q, in_ready_d;

  assign s_v = (state_q == ST_TWO);
  // Ready comes straight from a flop; reset only masks it so nothing is taken while in reset
  assign in_ready = in_ready_q && !reset;
`else
  assign s_v = 1'b0;
  // Classic stall register: room exists if empty or the head leaves this cycle
  assign in_ready = !reset && (!m_v || out_ready);
`endif

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = m_v && out_ready;
  assign out_valid = m_v;
  assign out_data  = m_data_q;
  assign count     = {1'b0, m_v} + {1'b0, s_v};

  // Next-state and data movement; flush overrides the handshake result
  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
`ifdef PIPE_STAGE_BUF_SKID_EN
    s_data_d   = s_data_q;
    in_ready_d = 1'b1;
`endif
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          m_data_d = in_data;
          state_d  = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          m_data_d = in_data;
        end else if (out_fire) begin
          m_data_d = BUBBLE;
          state_d  = ST_EMPTY;
        end
`ifdef PIPE_STAGE_BUF_SKID_EN
        else if (in_fire) begin
          s_data_d = in_data;
          state_d  = ST_TWO;
        end
`endif
      end
`ifdef PIPE_STAGE_BUF_SKID_EN
      ST_TWO: begin
        if (out_fire) begin
          m_data_d = s_data_q;
          s_data_d = BUBBLE;
          state_d  = ST_ONE;
        end
      end
`endif
      default: begin
        m_data_d = BUBBLE;
        state_d  = ST_EMPTY;
      end
    endcase
    if (flush) begin
      state_d  = ST_EMPTY;
      m_data_d = BUBBLE;
`ifdef PIPE_STAGE_BUF_SKID_EN
      s_data_d = BUBBLE;
`endif
    end
`ifdef PIPE_STAGE_BUF_SKID_EN
    in_ready_d = (state_d != ST_TWO);
`endif
  end

  // State and payload registers; reset drops every held beat
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      m_data_q <= BUBBLE;
`ifdef PIPE_STAGE_BUF_SKID_EN
      s_data_q   <= BUBBLE;
      in_ready_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
`ifdef PIPE_STAGE_BUF_SKID_EN
      s_data_q   <= s_data_d;
      in_ready_q <= in_ready_d;
`endif
    end
  end

endmodule
